// File: rtl/draw_scheduler.sv
// Single owner of the VGA pixel-write port: on each tick, redraws the 3x3 ship
// and then erases, advances and redraws the bullet as one sequenced pixel stream.
module draw_scheduler #(
  parameter int         SHIP_X        = 80,
  parameter int         SHIP_Y        = 60,
  parameter int         X_MAX         = 159,
  parameter int         Y_MAX         = 119,
  parameter logic [2:0] SHIP_COLOUR   = 3'b111,
  parameter logic [2:0] BULLET_COLOUR = 3'b100,
  parameter logic [2:0] BG_COLOUR     = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       tick,
  input  logic [1:0] direction,
  input  logic       fire,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       writeEn,
  output logic       busy,
  output logic       bullet_active
);

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE_SHIP, S_DRAW_SHIP, S_ERASE_B, S_MOVE_B, S_DRAW_B
  } state_t;

  localparam logic [1:0] DIR_UP = 2'b00, DIR_DOWN = 2'b01, DIR_RIGHT = 2'b10, DIR_LEFT = 2'b11;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_i, w_i_nxt;
  logic [1:0] r_dir, w_dir_nxt, r_bdir, w_bdir_nxt;
  logic [7:0] r_bx, w_bx_nxt, r_x, w_x_nxt;
  logic [6:0] r_by, w_by_nxt, r_y, w_y_nxt;
  logic [2:0] r_colour, w_colour_nxt;
  logic       r_fp, w_fp_nxt, r_bact, w_bact_nxt;
  logic       r_we, w_we_nxt, r_busy, w_busy_nxt;
  logic [8:0] w_mask;

  function automatic logic [7:0] pix_x(input logic [3:0] idx);
    logic [3:0] col;
    col = idx % 4'd3;
    return 8'(SHIP_X) + {4'd0, col} - 8'd1;
  endfunction

  function automatic logic [6:0] pix_y(input logic [3:0] idx);
    logic [3:0] row;
    row = idx / 4'd3;
    return 7'(SHIP_Y) + {3'd0, row} - 7'd1;
  endfunction

  // Bit index = row*3 + col, col 0 being the leftmost pixel.
  function automatic logic [8:0] ship_mask(input logic [1:0] dir);
    case (dir)
      DIR_UP:    return 9'b101_111_010;
      DIR_DOWN:  return 9'b010_111_101;
      DIR_LEFT:  return 9'b110_011_110;
      default:   return 9'b011_110_011;
    endcase
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_i_nxt     = r_i;
    w_dir_nxt   = r_dir;
    w_bdir_nxt  = r_bdir;
    w_bx_nxt    = r_bx;
    w_by_nxt    = r_by;
    w_bact_nxt  = r_bact;
    w_fp_nxt    = r_fp | (fire & ~r_bact);

    case (r_state)
      S_IDLE: begin
        if (tick) begin
          w_dir_nxt   = direction;
          w_i_nxt     = 4'd0;
          w_state_nxt = S_ERASE_SHIP;
        end
      end
      S_ERASE_SHIP: begin
        w_i_nxt = (r_i == 4'd8) ? 4'd0 : r_i + 4'd1;
        if (r_i == 4'd8) w_state_nxt = S_DRAW_SHIP;
      end
      S_DRAW_SHIP: begin
        w_i_nxt = (r_i == 4'd8) ? 4'd0 : r_i + 4'd1;
        if (r_i == 4'd8) w_state_nxt = (r_bact || r_fp) ? S_ERASE_B : S_IDLE;
      end
      S_ERASE_B: w_state_nxt = S_MOVE_B;
      S_MOVE_B: begin
        w_state_nxt = S_DRAW_B;
        if (r_bact) begin
          // Bounds are tested before stepping so coordinates never wrap.
          case (r_bdir)
            DIR_UP:    if (r_by == 7'd0)         w_bact_nxt = 1'b0; else w_by_nxt = r_by - 7'd1;
            DIR_DOWN:  if (r_by == 7'(Y_MAX))    w_bact_nxt = 1'b0; else w_by_nxt = r_by + 7'd1;
            DIR_LEFT:  if (r_bx == 8'd0)         w_bact_nxt = 1'b0; else w_bx_nxt = r_bx - 8'd1;
            default:   if (r_bx == 8'(X_MAX))    w_bact_nxt = 1'b0; else w_bx_nxt = r_bx + 8'd1;
          endcase
        end else if (r_fp) begin
          w_bdir_nxt = r_dir;
          w_bact_nxt = 1'b1;
          w_fp_nxt   = 1'b0;
          w_bx_nxt   = 8'(SHIP_X);
          w_by_nxt   = 7'(SHIP_Y);
          case (r_dir)
            DIR_UP:    w_by_nxt = 7'(SHIP_Y - 2);
            DIR_DOWN:  w_by_nxt = 7'(SHIP_Y + 2);
            DIR_LEFT:  w_bx_nxt = 8'(SHIP_X - 2);
            default:   w_bx_nxt = 8'(SHIP_X + 2);
          endcase
        end
      end
      S_DRAW_B: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase

    // Outputs are decoded from next-state values so the registered pixel lines up with its state.
    w_x_nxt      = 8'd0;
    w_y_nxt      = 7'd0;
    w_colour_nxt = 3'd0;
    w_we_nxt     = 1'b0;
    w_busy_nxt   = (w_state_nxt != S_IDLE);
    w_mask       = ship_mask(w_dir_nxt);
    case (w_state_nxt)
      S_ERASE_SHIP: begin
        w_x_nxt = pix_x(w_i_nxt); w_y_nxt = pix_y(w_i_nxt);
        w_colour_nxt = BG_COLOUR; w_we_nxt = 1'b1;
      end
      S_DRAW_SHIP: begin
        w_x_nxt = pix_x(w_i_nxt); w_y_nxt = pix_y(w_i_nxt);
        w_colour_nxt = SHIP_COLOUR; w_we_nxt = w_mask[w_i_nxt];
      end
      S_ERASE_B: begin
        w_x_nxt = w_bx_nxt; w_y_nxt = w_by_nxt;
        w_colour_nxt = BG_COLOUR; w_we_nxt = w_bact_nxt;
      end
      S_DRAW_B: begin
        w_x_nxt = w_bx_nxt; w_y_nxt = w_by_nxt;
        w_colour_nxt = BULLET_COLOUR; w_we_nxt = w_bact_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_i      <= 4'd0;
      r_dir    <= 2'b00;
      r_bdir   <= 2'b00;
      r_bx     <= 8'd0;
      r_by     <= 7'd0;
      r_fp     <= 1'b0;
      r_bact   <= 1'b0;
      r_x      <= 8'd0;
      r_y      <= 7'd0;
      r_colour <= 3'd0;
      r_we     <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_i      <= w_i_nxt;
      r_dir    <= w_dir_nxt;
      r_bdir   <= w_bdir_nxt;
      r_bx     <= w_bx_nxt;
      r_by     <= w_by_nxt;
      r_fp     <= w_fp_nxt;
      r_bact   <= w_bact_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_colour <= w_colour_nxt;
      r_we     <= w_we_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign x             = r_x;
  assign y             = r_y;
  assign colour        = r_colour;
  assign writeEn       = r_we;
  assign busy          = r_busy;
  assign bullet_active = r_bact;

endmodule

// File: tb/tb_draw_scheduler.sv
// Randomized bench for draw_scheduler: a per-tick model lists the expected pixel
// stream and bullet state, and every output cycle is compared against it.
module tb_draw_scheduler;

  localparam int SHIP_X = 80, SHIP_Y = 60, X_MAX = 159, Y_MAX = 119;
  localparam int C_SHIP = 7, C_BULLET = 4, C_BG = 0;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] direction = 2'b00;
  logic       fire = 1'b0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       writeEn, busy, bullet_active;

  draw_scheduler dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .tick(tick), .direction(direction),
    .fire(fire), .x(x), .y(y), .colour(colour), .writeEn(writeEn),
    .busy(busy), .bullet_active(bullet_active)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // Reference model: screen-level bullet state.
  bit m_bact = 0, m_fp = 0;
  int m_bx = 0, m_by = 0, m_bdir = 0;

  typedef struct { bit we; int x; int y; int c; bit bact; } cyc_t;

  function automatic string mask_row(int d, int r);
    string up[3]    = '{"010", "111", "101"};
    string down[3]  = '{"101", "111", "010"};
    string right[3] = '{"110", "011", "110"};
    string left[3]  = '{"011", "110", "011"};
    case (d)
      0: return up[r];
      1: return down[r];
      2: return right[r];
      default: return left[r];
    endcase
  endfunction

  function automatic bit mask_on(int d, int k);
    string s;
    s = mask_row(d, k / 3);
    return s.substr(k % 3, k % 3) == "1";
  endfunction

  task automatic model_move(input int d);
    if (m_bact) begin
      case (m_bdir)
        0: if (m_by == 0) m_bact = 0; else m_by--;
        1: if (m_by == Y_MAX) m_bact = 0; else m_by++;
        2: if (m_bx == X_MAX) m_bact = 0; else m_bx++;
        default: if (m_bx == 0) m_bact = 0; else m_bx--;
      endcase
    end else if (m_fp) begin
      m_bdir = d; m_bact = 1; m_fp = 0;
      m_bx = SHIP_X; m_by = SHIP_Y;
      case (d)
        0: m_by = SHIP_Y - 2;
        1: m_by = SHIP_Y + 2;
        2: m_bx = SHIP_X + 2;
        default: m_bx = SHIP_X - 2;
      endcase
    end
  endtask

  task automatic pulse_fire();
    @(negedge CLOCK_50);
    fire = 1'b1;
    @(negedge CLOCK_50);
    fire = 1'b0;
    if (!m_bact) m_fp = 1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    m_bact = 0; m_fp = 0;
    repeat (3) @(negedge CLOCK_50);
    resetn = 1'b1;
  endtask

  // One tick: direction d, optional extra tick/fire pulses in cycle 5, optional reset in cycle rst_at.
  task automatic run_tick(input int d, input bit inj_tick, input bit inj_fire, input int rst_at);
    cyc_t tr[$];
    cyc_t e;
    bit   bact0;
    bact0 = m_bact;
    if (inj_fire && !m_bact) m_fp = 1;
    for (int k = 0; k < 9; k++)
      tr.push_back('{1'b1, SHIP_X + k % 3 - 1, SHIP_Y + k / 3 - 1, C_BG, bact0});
    for (int k = 0; k < 9; k++)
      tr.push_back('{mask_on(d, k), SHIP_X + k % 3 - 1, SHIP_Y + k / 3 - 1, C_SHIP, bact0});
    if (m_bact || m_fp) begin
      tr.push_back('{m_bact, m_bx, m_by, C_BG, bact0});
      model_move(d);
      tr.push_back('{1'b0, 0, 0, 0, bact0});
      tr.push_back('{m_bact, m_bx, m_by, C_BULLET, m_bact});
    end

    @(negedge CLOCK_50);
    direction = 2'(d);
    tick = 1'b1;
    @(negedge CLOCK_50);
    tick = 1'b0;
    for (int k = 1; k <= tr.size(); k++) begin
      e = tr[k-1];
      chk($sformatf("we c%0d", k), 32'(writeEn), 32'(e.we));
      if (e.we)
        chk($sformatf("pix c%0d", k), 32'({x, y, colour}), 32'({e.x[7:0], e.y[6:0], e.c[2:0]}));
      chk($sformatf("busy c%0d", k), 32'(busy), 32'd1);
      chk($sformatf("bact c%0d", k), 32'(bullet_active), 32'(e.bact));
      if (k == rst_at) begin
        #2 resetn = 1'b0;
        #1;
        chk("rst we", 32'(writeEn), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst bact", 32'(bullet_active), 32'd0);
        m_bact = 0; m_fp = 0;
        repeat (2) @(negedge CLOCK_50);
        resetn = 1'b1;
        return;
      end
      if (k == 5) begin
        tick = inj_tick;
        fire = inj_fire;
      end else begin
        tick = 1'b0;
        fire = 1'b0;
      end
      @(negedge CLOCK_50);
    end
    tick = 1'b0;
    fire = 1'b0;
    chk("idle busy", 32'(busy), 32'd0);
    chk("idle we", 32'(writeEn), 32'd0);
    chk("idle bact", 32'(bullet_active), 32'(m_bact));
  endtask

  initial begin
    // Reset then idle
    do_reset();
    for (int c = 0; c < 50; c++) begin
      @(negedge CLOCK_50);
      chk("idle50 we", 32'(writeEn), 32'd0);
    end
    chk("rst xyc", 32'({x, y, colour}), 32'd0);
    chk("rst busy0", 32'(busy), 32'd0);
    chk("rst bact0", 32'(bullet_active), 32'd0);

    // Ship up, no bullet; then fire up and one more step
    run_tick(0, 0, 0, 0);
    pulse_fire();
    run_tick(0, 0, 0, 0);
    chk("spawn pos", 32'({m_bx[7:0], m_by[6:0]}), 32'({8'd80, 7'd58}));
    run_tick(2, 0, 0, 0);

    // Ignored events: extra tick and fire during an active bullet
    run_tick(1, 1, 1, 0);

    // Fly the up-bound bullet off the top edge
    for (int n = 0; n < 130 && m_bact; n++)
      run_tick(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    chk("exit up", 32'(bullet_active), 32'd0);

    // Randomized ticks
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) pulse_fire();
      run_tick(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 0);
    end
    for (int n = 0; n < 200 && m_bact; n++)
      run_tick(int'($urandom_range(0, 3)), 0, 0, 0);
    chk("drained", 32'(bullet_active), 32'd0);

    // Reset mid-sequence with a live bullet
    pulse_fire();
    run_tick(3, 0, 0, 0);
    run_tick(0, 0, 0, 10);
    chk("post rst xyc", 32'({x, y, colour}), 32'd0);
    run_tick(1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
